// File: rtl/traffic_light_monitor.sv
// Safety and timing checker for the intersection light controller: decodes the
// active phase from the six lamps and latches the first lamp/order/duration violation.
module traffic_light_monitor #(
    parameter int GREEN_TICKS  = 5,
    parameter int YELLOW_TICKS = 2,
    parameter int CNT_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             ns_g,
    input  logic             ns_y,
    input  logic             ns_r,
    input  logic             ew_g,
    input  logic             ew_y,
    input  logic             ew_r,
    input  logic             clr_fault,
    output logic [1:0]       phase,
    output logic             phase_valid,
    output logic [CNT_W-1:0] phase_ticks,
    output logic [15:0]      cycle_count,
    output logic             fault,
    output logic [2:0]       fault_code,
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [1:0] PH_NS_G = 2'd0;
    localparam logic [1:0] PH_NS_Y = 2'd1;
    localparam logic [1:0] PH_EW_G = 2'd2;
    localparam logic [1:0] PH_EW_Y = 2'd3;

    localparam logic [2:0] FC_NONE    = 3'd0;
    localparam logic [2:0] FC_LAMPS   = 3'd1;
    localparam logic [2:0] FC_ORDER   = 3'd2;
    localparam logic [2:0] FC_SHORT   = 3'd3;
    localparam logic [2:0] FC_OVERRUN = 3'd4;

    localparam logic [CNT_W-1:0] GREEN_CNT  = CNT_W'(GREEN_TICKS);
    localparam logic [CNT_W-1:0] YELLOW_CNT = CNT_W'(YELLOW_TICKS);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] ticks_q, ticks_d;
    logic [15:0]      count_q, count_d;
    logic             fault_q, fault_d;
    logic [2:0]       code_q, code_d;

    logic [5:0]       lamps;
    logic             legal;
    logic [1:0]       cur_phase;
    logic             change;
    logic [CNT_W-1:0] exp_ticks;
    logic [2:0]       det_code;

    assign lamps = {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r};

    // Only the four exact one-red patterns are legal; everything else is a lamp fault.
    always_comb begin
        legal     = 1'b1;
        cur_phase = phase_q;
        case (lamps)
            6'b100_001: cur_phase = PH_NS_G;
            6'b010_001: cur_phase = PH_NS_Y;
            6'b001_100: cur_phase = PH_EW_G;
            6'b001_010: cur_phase = PH_EW_Y;
            default:    legal     = 1'b0;
        endcase
    end

    assign change    = legal && (cur_phase != phase_q);
    assign exp_ticks = phase_q[0] ? YELLOW_CNT : GREEN_CNT;

    // Violation detection in priority order; order/duration only matter once in RUN.
    always_comb begin
        det_code = FC_NONE;
        if (state_q != ST_FAULT) begin
            if (!legal) begin
                det_code = FC_LAMPS;
            end else if (state_q == ST_RUN) begin
                if (change && (cur_phase != phase_q + 2'd1)) begin
                    det_code = FC_ORDER;
                end else if (change && (ticks_q < exp_ticks)) begin
                    det_code = FC_SHORT;
                end else if (!change && tick && (ticks_q == exp_ticks)) begin
                    det_code = FC_OVERRUN;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = legal ? cur_phase : phase_q;
        valid_d = legal;
        ticks_d = ticks_q;
        count_d = count_q;
        fault_d = fault_q;
        code_d  = code_q;

        if (change) begin
            ticks_d = '0;
        end else if (tick && (ticks_q != CNT_MAX)) begin
            ticks_d = ticks_q + 1'b1;
        end

        case (state_q)
            ST_SYNC: begin
                if (det_code != FC_NONE) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                    code_d  = det_code;
                end else if (change) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (det_code != FC_NONE) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                    code_d  = det_code;
                    // The overrunning tick is not counted, so phase_ticks shows the
                    // full legal duration at the moment of the fault.
                    if (det_code == FC_OVERRUN) begin
                        ticks_d = ticks_q;
                    end
                end else if (change && (phase_q == PH_EW_Y) && (cur_phase == PH_NS_G)
                             && (count_q != 16'hFFFF)) begin
                    count_d = count_q + 16'd1;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_SYNC;
            end
        endcase

        if (clr_fault) begin
            state_d = ST_SYNC;
            fault_d = 1'b0;
            code_d  = FC_NONE;
            ticks_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_SYNC;
            phase_q <= PH_NS_G;
            valid_q <= 1'b0;
            ticks_q <= '0;
            count_q <= '0;
            fault_q <= 1'b0;
            code_q  <= FC_NONE;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            valid_q <= valid_d;
            ticks_q <= ticks_d;
            count_q <= count_d;
            fault_q <= fault_d;
            code_q  <= code_d;
        end
    end

    assign phase       = phase_q;
    assign phase_valid = valid_q;
    assign phase_ticks = ticks_q;
    assign cycle_count = count_q;
    assign fault       = fault_q;
    assign fault_code  = code_q;
    assign dbg_state_o = state_q;

endmodule
